// File: rtl/vram_arbiter_if.sv
// Bundle of the timing, write-port, clear-control, char-RAM and fetch-output
// signals that surround the character RAM arbiter.
interface vram_arbiter_if;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        wr_req;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        cls_req;
  logic        cls_busy;
  logic        cls_done;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_valid;

  modport slave (
    input  hc, vc, wr_req, wr_addr, wr_data, cls_req, ram_rdata,
    output wr_ack, cls_busy, cls_done, ram_addr, ram_we, ram_wdata,
           char_code, char_valid
  );

  modport master (
    output hc, vc, wr_req, wr_addr, wr_data, cls_req, ram_rdata,
    input  wr_ack, cls_busy, cls_done, ram_addr, ram_we, ram_wdata,
           char_code, char_valid
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port char RAM arbiter: display fetch slots (from hc/vc) always win,
// remaining cycles go to the clear-screen sequencer, then to the write port.
module vram_arbiter #(
  parameter int unsigned HBP        = 112,
  parameter int unsigned HVIS       = 512,
  parameter int unsigned VBP        = 145,
  parameter int unsigned VVIS       = 256,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned CHAR_H     = 16,
  parameter int unsigned COLS       = 64,
  parameter int unsigned FETCH_LEAD = 8,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input logic           px_clk,
  input logic           clr,
  vram_arbiter_if.slave bus
);

  localparam int unsigned HSTART = HBP - FETCH_LEAD;
  localparam int unsigned HEND   = HBP + HVIS - FETCH_LEAD;
  localparam int unsigned VEND   = VBP + VVIS;
  localparam int unsigned CW_SH  = $clog2(CHAR_W);
  localparam int unsigned CH_SH  = $clog2(CHAR_H);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [9:0]  clr_cnt;
  logic [10:0] hc_off;
  logic [10:0] vc_off;
  logic        slot;
  logic [9:0]  slot_addr;
  logic        clr_go;
  logic        wr_go;

  logic [9:0]  ram_addr_q;
  logic        ram_we_q;
  logic [7:0]  ram_wdata_q;
  logic        wr_ack_q;
  logic        cls_done_q;
  logic        fetch_q;
  logic [7:0]  char_code_q;
  logic        char_valid_q;

  assign hc_off = bus.hc - 11'(HSTART);
  assign vc_off = bus.vc - 11'(VBP);

  assign slot = (bus.vc >= 11'(VBP))    && (bus.vc < 11'(VEND)) &&
                (bus.hc >= 11'(HSTART)) && (bus.hc < 11'(HEND)) &&
                ((hc_off & 11'(CHAR_W - 1)) == '0);

  assign slot_addr = 10'(((vc_off >> CH_SH) * 11'(COLS)) + (hc_off >> CW_SH));

  // A write also yields to a same-cycle cls_req and to its own ack cycle,
  // which caps the write port at one grant every two cycles.
  assign clr_go = !slot && (state_q == CLEARING);
  assign wr_go  = !slot && (state_q == IDLE) && bus.wr_req && !wr_ack_q && !bus.cls_req;

  // Clear sequencer state register.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Clear sequencer next state: start on cls_req, finish after writing 1023.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.cls_req) state_d = CLEARING;
      CLEARING: if (clr_go && (clr_cnt == '1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Clear address counter; held during fetch slots.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr)                                   clr_cnt <= '0;
    else if ((state_q == IDLE) && bus.cls_req) clr_cnt <= '0;
    else if (clr_go)                           clr_cnt <= clr_cnt + 10'd1;
  end

  // Registered RAM port and handshake pulses for this cycle's winner.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      cls_done_q  <= 1'b0;
      fetch_q     <= 1'b0;
    end else begin
      ram_we_q   <= clr_go || wr_go;
      wr_ack_q   <= wr_go;
      cls_done_q <= clr_go && (clr_cnt == '1);
      fetch_q    <= slot;
      if (slot) begin
        ram_addr_q <= slot_addr;
      end else if (clr_go) begin
        ram_addr_q  <= clr_cnt;
        ram_wdata_q <= FILL_CHAR;
      end else if (wr_go) begin
        ram_addr_q  <= bus.wr_addr;
        ram_wdata_q <= bus.wr_data;
      end
    end
  end

  // Capture read data one cycle after a fetch address was presented.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      char_code_q  <= '0;
      char_valid_q <= 1'b0;
    end else begin
      char_valid_q <= fetch_q;
      if (fetch_q) char_code_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.cls_busy   = (state_q == CLEARING);
  assign bus.cls_done   = cls_done_q;
  assign bus.char_code  = char_code_q;
  assign bus.char_valid = char_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1024x8 char RAM model.
module tb_vram_arbiter;
  logic px_clk = 1'b0;
  logic clr;
  logic pre_req;
  logic pre_rand;
  logic [7:0] mem [1024];
  int n_checks = 0;
  int n_errors = 0;

  always #5 px_clk = ~px_clk;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .px_clk (px_clk),
    .clr    (clr),
    .bus    (bus)
  );

  // RAM model: write on clock, read data follows the presented address.
  always @(posedge px_clk) begin
    if (pre_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre_rand ? 8'($urandom_range(0, 255)) : 8'(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  function automatic bit is_slot(int h, int v);
    return (v >= 145) && (v < 401) && (h >= 104) && (h < 616) && (((h - 104) % 8) == 0);
  endfunction

  task automatic park();
    bus.hc = 11'd0;
    bus.vc = 11'd0;
    repeat (3) tick();
  endtask

  task automatic preload(input logic rnd);
    pre_rand = rnd;
    pre_req  = 1'b1;
    tick();
    pre_req  = 1'b0;
    tick();
  endtask

  // One line sweep hc=100..620; outputs sampled belong to the driven hc.
  task automatic sweep(input int v, input int base, input int exp_pulses);
    int k;
    k = 0;
    bus.vc = 11'(v);
    for (int h = 100; h <= 620; h++) begin
      bus.hc = 11'(h);
      if (bus.char_valid) begin
        check("fetch_hc", h, 106 + 8 * k);
        check("fetch_code", bus.char_code, 32'((base + k) % 256));
        k++;
      end
      tick();
    end
    check("fetch_count", k, exp_pulses);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, t_ack, busy_n, done_n, wr_n, bad, viol, ferr, fetch_n, h, v;
    bit p1, p2, cur;

    clr = 1'b1; pre_req = 1'b0; pre_rand = 1'b0;
    bus.hc = '0; bus.vc = '0;
    bus.wr_req = 1'b1; bus.wr_addr = 10'h155; bus.wr_data = 8'hC3; bus.cls_req = 1'b0;

    // Reset with pending requests
    repeat (2) tick();
    bus.cls_req = 1'b1; tick(); bus.cls_req = 1'b0; tick();
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_cls_busy", bus.cls_busy, 0);
    check("rst_cls_done", bus.cls_done, 0);
    check("rst_char_code", bus.char_code, 0);
    check("rst_char_valid", bus.char_valid, 0);
    clr = 1'b0;
    check("rst_no_early_ack", bus.wr_ack, 0);
    tick();
    check("rst_first_ack", bus.wr_ack, 1);
    check("rst_first_addr", bus.ram_addr, 10'h155);
    check("rst_first_data", bus.ram_wdata, 8'hC3);
    check("rst_cls_ignored", bus.cls_busy, 0);
    bus.wr_req = 1'b0;
    tick();
    check("rst_no_double_ack", bus.wr_ack, 0);

    // Display fetch
    preload(1'b0);
    park(); sweep(145, 0, 64);
    park(); sweep(161, 64, 64);
    park(); sweep(144, 0, 0);
    park(); sweep(401, 0, 0);

    // Write around the slot at hc=112
    park();
    bus.vc = 11'd145;
    bus.hc = 11'd110; tick();
    bus.hc = 11'd111; bus.wr_req = 1'b1; bus.wr_addr = 10'd900; bus.wr_data = 8'hA5;
    check("act_ack_111", bus.wr_ack, 0);
    tick();
    bus.hc = 11'd112;
    check("act_ack_112", bus.wr_ack, 1);
    check("act_we_112", bus.ram_we, 1);
    check("act_addr_112", bus.ram_addr, 900);
    bus.wr_req = 1'b0;
    tick();
    bus.hc = 11'd113;
    check("act_fetch_addr_113", bus.ram_addr, 1);
    check("act_we_113", bus.ram_we, 0);
    tick();
    bus.hc = 11'd111; tick();
    bus.hc = 11'd112; bus.wr_req = 1'b1; bus.wr_addr = 10'd901; bus.wr_data = 8'h5A;
    tick();
    bus.hc = 11'd113;
    check("defer_ack_113", bus.wr_ack, 0);
    check("defer_fetch_addr_113", bus.ram_addr, 1);
    tick();
    bus.hc = 11'd114;
    check("defer_ack_114", bus.wr_ack, 1);
    check("defer_addr_114", bus.ram_addr, 901);
    check("defer_char_valid_114", bus.char_valid, 1);
    check("defer_char_code_114", bus.char_code, 1);
    bus.wr_req = 1'b0;
    tick();
    park();
    check("act_mem_900", mem[900], 8'hA5);
    check("act_mem_901", mem[901], 8'h5A);

    // Back-to-back writes in blanking
    k = 0;
    bus.wr_req = 1'b1; bus.wr_addr = 10'd300; bus.wr_data = 8'h40;
    for (int c = 0; c < 10; c++) begin
      check("b2b_ack", bus.wr_ack, ((c % 2) == 1) && (c <= 7));
      if (bus.wr_ack) begin
        k++;
        if (k == 4) bus.wr_req = 1'b0;
        else begin
          bus.wr_addr = 10'(300 + k);
          bus.wr_data = 8'(8'h40 + k);
        end
      end
      tick();
    end
    for (int j = 0; j < 4; j++) check("b2b_mem", mem[300 + j], 32'(8'h40 + j));

    // Clear during vblank with a concurrent write request
    preload(1'b1);
    park();
    t_ack = -1; busy_n = 0; done_n = 0; wr_n = 0;
    bus.cls_req = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 8'h77;
    for (int c = 0; c < 1100; c++) begin
      if (bus.cls_busy) busy_n++;
      if (bus.cls_done) done_n++;
      if (bus.ram_we && !bus.wr_ack) wr_n++;
      if (bus.wr_ack) begin
        if (t_ack < 0) t_ack = c;
        bus.wr_req = 1'b0;
      end
      tick();
      bus.cls_req = 1'b0;
    end
    check("cls_busy_cycles", busy_n, 1024);
    check("cls_done_count", done_n, 1);
    check("cls_write_count", wr_n, 1024);
    check("cls_wr_ack_cycle", t_ack, 1026);
    bad = 0;
    for (int i = 0; i < 1024; i++) if ((i != 5) && (mem[i] != 8'h20)) bad++;
    check("cls_mem_fill", bad, 0);
    check("cls_mem_after_write", mem[5], 8'h77);

    // Clear spanning active video
    preload(1'b1);
    park();
    h = 0; v = 145; p1 = 1'b0; p2 = 1'b0;
    viol = 0; ferr = 0; wr_n = 0; done_n = 0; fetch_n = 0;
    bus.cls_req = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      bus.hc = 11'(h);
      bus.vc = 11'(v);
      cur = is_slot(h, v);
      if (bus.ram_we && p1) viol++;
      if (bus.char_valid !== p2) ferr++;
      if (bus.char_valid) fetch_n++;
      if (bus.ram_we) wr_n++;
      if (bus.cls_done) done_n++;
      tick();
      bus.cls_req = 1'b0;
      p2 = p1; p1 = cur;
      h++;
      if (h == 800) begin h = 0; v++; end
    end
    check("span_slot_writes", viol, 0);
    check("span_fetch_pattern", ferr, 0);
    check("span_fetch_count", fetch_n, 165);
    check("span_write_count", wr_n, 1024);
    check("span_done_count", done_n, 1);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 8'h20) bad++;
    check("span_mem_fill", bad, 0);

    // clr asserted mid-clear
    park();
    bus.cls_req = 1'b1; tick(); bus.cls_req = 1'b0;
    repeat (100) tick();
    check("abort_busy_before", bus.cls_busy, 1);
    #2;
    clr = 1'b1;
    #1;
    check("abort_busy", bus.cls_busy, 0);
    check("abort_we", bus.ram_we, 0);
    check("abort_addr", bus.ram_addr, 0);
    check("abort_wdata", bus.ram_wdata, 0);
    tick();
    clr = 1'b0;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 1100; c++) begin
      if (bus.cls_busy) busy_n++;
      if (bus.cls_done) done_n++;
      tick();
    end
    check("abort_no_busy", busy_n, 0);
    check("abort_no_done", done_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
